cmult_pipe: RTL and testbench

Parametrised, pipelined complex multiplier with valid/ready flow control, per-sample conjugate mode, and a configurable output scaler with round-half-up. Computes a·b or a·conj(b) on signed I/Q operands. Sits in the DSP datapath behind the NCO/mixer stages, where the combinational multiplier is too slow and carries no flow control.

---
 rtl/cmult_pipe.sv | 131 +++++++++++++
 tb/tb_cmult_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmult_pipe.sv
// cmult_pipe: four-stage pipelined complex multiplier (a*b or a*conj(b)) with valid/ready
// flow control and round-half-up output scaling. Define CMULT_SAT_EN to saturate instead of wrap.
module cmult_pipe #(
    parameter int DW    = 18,
    parameter int OW    = 18,
    parameter int SHIFT = 17,
    parameter int TW    = 1
) (
    input  logic                 clk_i,
    input  logic                 srst_n,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic signed [DW-1:0] a_i_i,
    input  logic signed [DW-1:0] a_q_i,
    input  logic signed [DW-1:0] b_i_i,
    input  logic signed [DW-1:0] b_q_i,
    input  logic                 conj_i,
    input  logic [TW-1:0]        tag_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic signed [OW-1:0] data_i_o,
    output logic signed [OW-1:0] data_q_o,
    output logic [TW-1:0]        tag_o,
    output logic                 ovf_o
);
    localparam int PW = 2 * DW;
    localparam int FW = 2 * DW + 1;
    // Half an LSB of the scaled result; zero when SHIFT is 0.
    localparam logic [FW:0] RND = ({{FW{1'b0}}, 1'b1} << SHIFT) >> 1;

    function automatic logic signed [FW:0] round_shift(input logic signed [FW-1:0] p);
        logic signed [FW:0] ext;
        ext = $signed({p[FW-1], p}) + $signed(RND);
        return ext >>> SHIFT;
    endfunction

    // Returns {overflow, value}.
`ifdef CMULT_SAT_EN
    function automatic logic [OW:0] saturate(input logic signed [FW:0] r);
        logic [FW-OW+1:0] top;
        top = r[FW:OW-1];
        if ((&top) || !(|top))
            return {1'b0, r[OW-1:0]};
        return {1'b1, r[FW], {(OW-1){~r[FW]}}};
    endfunction
`else
    function automatic logic [OW:0] saturate(input logic signed [FW:0] r);
        return {1'b0, r[OW-1:0]};
    endfunction
`endif

    logic adv;
    assign adv     = !valid_o || ready_i;
    assign ready_o = adv;

    logic                 vld_p1, vld_p2, vld_p3;
    logic signed [DW-1:0] a_i_p1, a_q_p1, b_i_p1, b_q_p1;
    logic                 conj_p1, conj_p2;
    logic [TW-1:0]        tag_p1, tag_p2, tag_p3;
    logic signed [PW-1:0] pr_ii_p2, pr_qq_p2, pr_iq_p2, pr_qi_p2;
    logic signed [FW-1:0] sum_i_p3, sum_q_p3;
    logic [OW:0]          res_i, res_q;

    always_ff @(posedge clk_i or negedge srst_n) begin
        if (!srst_n) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            valid_o <= 1'b0;
        end else if (adv) begin
            vld_p1  <= valid_i;
            vld_p2  <= vld_p1;
            vld_p3  <= vld_p2;
            valid_o <= vld_p3;
        end
    end

    // S1: operand capture
    always_ff @(posedge clk_i) begin
        if (adv) begin
            a_i_p1  <= a_i_i;
            a_q_p1  <= a_q_i;
            b_i_p1  <= b_i_i;
            b_q_p1  <= b_q_i;
            conj_p1 <= conj_i;
            tag_p1  <= tag_i;
        end
    end

    // S2: four partial products at full width
    always_ff @(posedge clk_i) begin
        if (adv) begin
            pr_ii_p2 <= PW'(a_i_p1) * PW'(b_i_p1);
            pr_qq_p2 <= PW'(a_q_p1) * PW'(b_q_p1);
            pr_iq_p2 <= PW'(a_i_p1) * PW'(b_q_p1);
            pr_qi_p2 <= PW'(a_q_p1) * PW'(b_i_p1);
            conj_p2  <= conj_p1;
            tag_p2   <= tag_p1;
        end
    end

    // S3: sum/difference, one guard bit so nothing overflows
    always_ff @(posedge clk_i) begin
        if (adv) begin
            sum_i_p3 <= conj_p2 ? FW'(pr_ii_p2) + FW'(pr_qq_p2)
                                : FW'(pr_ii_p2) - FW'(pr_qq_p2);
            sum_q_p3 <= conj_p2 ? FW'(pr_qi_p2) - FW'(pr_iq_p2)
                                : FW'(pr_iq_p2) + FW'(pr_qi_p2);
            tag_p3   <= tag_p2;
        end
    end

    // S4: round, shift, reduce to OW into the output registers
    assign res_i = saturate(round_shift(sum_i_p3));
    assign res_q = saturate(round_shift(sum_q_p3));

    always_ff @(posedge clk_i or negedge srst_n) begin
        if (!srst_n) begin
            data_i_o <= '0;
            data_q_o <= '0;
            tag_o    <= '0;
            ovf_o    <= 1'b0;
        end else if (adv) begin
            data_i_o <= res_i[OW-1:0];
            data_q_o <= res_q[OW-1:0];
            tag_o    <= tag_p3;
            ovf_o    <= res_i[OW] | res_q[OW];
        end
    end

endmodule

// File: tb/tb_cmult_pipe.sv
// Directed bench for cmult_pipe: three parameterisations share one stimulus bus; a monitor
// scoreboards a randomly back-pressured stream on the default (18/18/17) instance.
module tb_cmult_pipe;

`ifdef CMULT_SAT_EN
    localparam longint CORNER_Q   = 131071;
    localparam longint CORNER_OVF = 1;
`else
    localparam longint CORNER_Q   = 0;
    localparam longint CORNER_OVF = 0;
`endif

    logic clk = 1'b0;
    logic srst_n;
    logic valid_i, ready_i, conj_i;
    logic signed [17:0] a_i, a_q, b_i, b_q;
    logic [0:0] tag_i;

    logic m_rdy, m_vld, m_ovf;
    logic signed [17:0] m_di, m_dq;
    logic [0:0] m_tag;
    logic w_rdy, w_vld, w_ovf;
    logic signed [36:0] w_di, w_dq;
    logic [0:0] w_tag;
    logic r_rdy, r_vld, r_ovf;
    logic signed [35:0] r_di, r_dq;
    logic [0:0] r_tag;

    always #5 clk = ~clk;

    cmult_pipe #(.DW(18), .OW(18), .SHIFT(17), .TW(1)) u_main (
        .clk_i(clk), .srst_n(srst_n), .valid_i(valid_i), .ready_o(m_rdy),
        .a_i_i(a_i), .a_q_i(a_q), .b_i_i(b_i), .b_q_i(b_q), .conj_i(conj_i), .tag_i(tag_i),
        .valid_o(m_vld), .ready_i(ready_i), .data_i_o(m_di), .data_q_o(m_dq),
        .tag_o(m_tag), .ovf_o(m_ovf));

    cmult_pipe #(.DW(18), .OW(37), .SHIFT(0), .TW(1)) u_wide (
        .clk_i(clk), .srst_n(srst_n), .valid_i(valid_i), .ready_o(w_rdy),
        .a_i_i(a_i), .a_q_i(a_q), .b_i_i(b_i), .b_q_i(b_q), .conj_i(conj_i), .tag_i(tag_i),
        .valid_o(w_vld), .ready_i(ready_i), .data_i_o(w_di), .data_q_o(w_dq),
        .tag_o(w_tag), .ovf_o(w_ovf));

    cmult_pipe #(.DW(18), .OW(36), .SHIFT(1), .TW(1)) u_rnd (
        .clk_i(clk), .srst_n(srst_n), .valid_i(valid_i), .ready_o(r_rdy),
        .a_i_i(a_i), .a_q_i(a_q), .b_i_i(b_i), .b_q_i(b_q), .conj_i(conj_i), .tag_i(tag_i),
        .valid_o(r_vld), .ready_i(ready_i), .data_i_o(r_di), .data_q_o(r_dq),
        .tag_o(r_tag), .ovf_o(r_ovf));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        longint     i;
        longint     q;
        logic       ovf;
        logic [0:0] tag;
    } beat_t;

    function automatic longint reduce18(input longint r, inout logic ovf);
        logic signed [17:0] w;
`ifdef CMULT_SAT_EN
        if (r > 131071) begin ovf = 1'b1; return 131071; end
        if (r < -131072) begin ovf = 1'b1; return -131072; end
        return r;
`else
        w = 18'(r);
        return longint'(w);
`endif
    endfunction

    function automatic beat_t model(input longint ai, aq, bi, bq, input logic cj,
                                    input logic [0:0] tg);
        beat_t  e;
        longint pi, pq;
        pi = cj ? ai * bi + aq * bq : ai * bi - aq * bq;
        pq = cj ? aq * bi - ai * bq : ai * bq + aq * bi;
        e.ovf = 1'b0;
        e.i   = reduce18((pi + 65536) >>> 17, e.ovf);
        e.q   = reduce18((pq + 65536) >>> 17, e.ovf);
        e.tag = tg;
        return e;
    endfunction

    task automatic set_beat(input longint ai, aq, bi, bq, input logic cj, input logic [0:0] tg);
        valid_i = 1'b1;
        a_i     = 18'(ai);
        a_q     = 18'(aq);
        b_i     = 18'(bi);
        b_q     = 18'(bq);
        conj_i  = cj;
        tag_i   = tg;
    endtask

    // Counts falling edges until the output beat shows up; 0 means it never did.
    task automatic wait_out(output int lat);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (m_vld) begin
                lat = k;
                break;
            end
        end
    endtask

    beat_t exp_q[$];
    bit    mon_en = 1'b0;
    int    n_out = 0;
    logic  hold_v = 1'b0;
    logic signed [17:0] hold_i, hold_q;
    logic  hold_ovf;
    logic [0:0] hold_tag;

    always @(negedge clk) begin
        if (mon_en) begin
            check("bp_ready", m_rdy, !(m_vld && !ready_i));
            if (hold_v) begin
                check("bp_hold_vld", m_vld, 1);
                check("bp_hold_i", m_di, hold_i);
                check("bp_hold_q", m_dq, hold_q);
                check("bp_hold_ovf", m_ovf, hold_ovf);
                check("bp_hold_tag", m_tag, hold_tag);
            end
            if (m_vld && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra_beat", 1, 0);
                end else begin
                    check("bp_i", m_di, exp_q[0].i);
                    check("bp_q", m_dq, exp_q[0].q);
                    check("bp_ovf", m_ovf, exp_q[0].ovf);
                    check("bp_tag", m_tag, exp_q[0].tag);
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
            hold_v   <= m_vld && !ready_i;
            hold_i   <= m_di;
            hold_q   <= m_dq;
            hold_ovf <= m_ovf;
            hold_tag <= m_tag;
        end else begin
            hold_v <= 1'b0;
        end
    end

    initial begin
        int lat;
        int guard;
        bit acc;
        logic signed [17:0] ra, rb, rc, rd;
        logic rcj;

        valid_i = 1'b0;
        ready_i = 1'b1;
        conj_i  = 1'b0;
        tag_i   = '0;
        a_i = '0; a_q = '0; b_i = '0; b_q = '0;
        srst_n  = 1'b1;
        #1 srst_n = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", m_vld, 0);
        check("rst_i", m_di, 0);
        check("rst_q", m_dq, 0);
        check("rst_tag", m_tag, 0);
        check("rst_ovf", m_ovf, 0);
        srst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", m_rdy, 1);

        // basic product and latency
        set_beat(65536, 0, 65536, 65536, 1'b0, 1'b1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        wait_out(lat);
        check("basic_lat", lat, 4);
        check("basic_i", m_di, 32768);
        check("basic_q", m_dq, 32768);
        check("basic_ovf", m_ovf, 0);
        check("basic_tag", m_tag, 1);

        // conjugate mode, full precision; first beat accepted one edge before the second
        @(posedge clk); #1;
        set_beat(3, 4, 1, 2, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_beat(3, 4, 1, 2, 1'b1, 1'b1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        wait_out(lat);
        check("conj_lat", lat, 3);
        check("conj0_i", w_di, -5);
        check("conj0_q", w_dq, 10);
        check("conj0_tag", w_tag, 0);
        @(negedge clk);
        check("conj1_vld", w_vld, 1);
        check("conj1_i", w_di, 11);
        check("conj1_q", w_dq, -2);
        check("conj1_tag", w_tag, 1);
        @(negedge clk);
        check("conj_nodup", w_vld, 0);

        // most-negative corner
        @(posedge clk); #1;
        set_beat(-131072, -131072, -131072, -131072, 1'b0, 1'b0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        wait_out(lat);
        check("corner_lat", lat, 4);
        check("corner_i", m_di, 0);
        check("corner_q", m_dq, CORNER_Q);
        check("corner_ovf", m_ovf, CORNER_OVF);

        // round half up with SHIFT=1
        @(posedge clk); #1;
        set_beat(3, 0, 1, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_beat(-3, 0, 1, 0, 1'b0, 1'b1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        wait_out(lat);
        check("rnd_pos_i", r_di, 2);
        check("rnd_pos_q", r_dq, 0);
        @(negedge clk);
        check("rnd_neg_vld", r_vld, 1);
        check("rnd_neg_i", r_di, -1);
        check("rnd_neg_q", r_dq, 0);

        // random backpressure stream
        @(posedge clk); #1;
        mon_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ra  = 18'($urandom);
            rb  = 18'($urandom);
            rc  = 18'($urandom);
            rd  = 18'($urandom);
            rcj = 1'($urandom_range(0, 1));
            set_beat(ra, rb, rc, rd, rcj, 1'(k));
            guard = 0;
            do begin
                @(negedge clk);
                acc = m_rdy;
                @(posedge clk); #1;
                ready_i = 1'($urandom_range(0, 1));
                guard++;
            end while (!acc && guard < 50);
            if (!acc) check("bp_accept_timeout", 0, 1);
            exp_q.push_back(model(ra, rb, rc, rd, rcj, 1'(k)));
        end
        valid_i = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            @(posedge clk); #1;
            ready_i = 1'($urandom_range(0, 1));
            guard++;
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b0;
        check("bp_count", n_out, 20);
        check("bp_left", exp_q.size(), 0);

        // reset with beats in flight behind a stalled output
        ready_i = 1'b0;
        set_beat(65536, 0, 65536, 65536, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_beat(65536, 0, 65536, 65536, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_beat(65536, 0, 65536, 65536, 1'b0, 1'b1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("mrst_pre_vld", m_vld, 1);
        check("mrst_pre_i", m_di, 32768);
        #2 srst_n = 1'b0;
        #1;
        check("mrst_vld", m_vld, 0);
        check("mrst_i", m_di, 0);
        check("mrst_q", m_dq, 0);
        check("mrst_tag", m_tag, 0);
        check("mrst_ovf", m_ovf, 0);
        check("mrst_ready", m_rdy, 1);
        @(posedge clk); #1;
        srst_n  = 1'b1;
        ready_i = 1'b1;
        @(posedge clk); #1;
        check("mrst_ready_rel", m_rdy, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("mrst_no_stale", m_vld, 0);
        end
        @(posedge clk); #1;
        set_beat(65536, 65536, 65536, 65536, 1'b0, 1'b1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        wait_out(lat);
        check("mrst_new_lat", lat, 4);
        check("mrst_new_i", m_di, 0);
        check("mrst_new_q", m_dq, 65536);
        check("mrst_new_tag", m_tag, 1);
        @(negedge clk);
        check("mrst_new_nodup", m_vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
